// File: rtl/sum_result_checker.sv
// ---------------------------------------------------------------------------
// sum_result_checker
//
// Purpose:
//   Self-checking stage that sits after the clocked radix adder in the adder
//   test harness. Each beat compares the adder sum against a golden expected
//   word and checks that the result address follows the order 0,1,2,...
//   At the end of a run it reports a pass/fail summary.
//
// Optional feature (macro FIRST_ERR_CAPTURE_EN):
//   When the macro is defined, the address, sum and expected word of the first
//   mismatching beat in a run are captured and then held. When it is
//   undefined, the first_err_* outputs are tied to 0.
//
// Ports:
//   pll_clock      in   sole clock, rising edge
//   reset          in   synchronous active-high reset
//   start          in   single-cycle pulse that arms a run (IDLE/DONE only)
//   length         in   beats in the run; 0 means 2^ADDR_WIDTH
//   in_valid       in   sum_in/exp_in/in_addr are valid this cycle
//   in_addr        in   result address of this beat
//   sum_in         in   adder output word
//   exp_in         in   golden expected word
//   busy           out  high in RUN and DRAIN
//   done           out  high in DONE
//   pass           out  run done with no mismatches and no sequence fault
//   err_count      out  mismatching beats, saturating
//   beat_count     out  beats accepted in this run
//   seq_err        out  sticky address-order fault
//   first_err_addr out  address of the first mismatch
//   first_err_sum  out  sum_in of the first mismatch
//   first_err_exp  out  exp_in of the first mismatch
// ---------------------------------------------------------------------------
module sum_result_checker #(
    parameter int WIDTH      = 64,
    parameter int ADDR_WIDTH = 9,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  pll_clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] length,
    input  logic                  in_valid,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [WIDTH-1:0]      sum_in,
    input  logic [WIDTH-1:0]      exp_in,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [ADDR_WIDTH:0]   beat_count,
    output logic                  seq_err,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [WIDTH-1:0]      first_err_sum,
    output logic [WIDTH-1:0]      first_err_exp
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [CNT_WIDTH-1:0] ERR_MAX = {CNT_WIDTH{1'b1}};

    state_t                state_q;
    logic                  drain_cnt_q;
    logic                  pass_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   beat_count_q;
    logic [CNT_WIDTH-1:0]  err_count_q;
    logic                  seq_err_q;
    logic [ADDR_WIDTH-1:0] exp_idx_q;

    // Stage 1 registers
    logic                  s1_valid_q;
    logic [ADDR_WIDTH-1:0] s1_addr_q;
    logic [WIDTH-1:0]      s1_sum_q;
    logic [WIDTH-1:0]      s1_exp_q;

    logic                  start_accept;
    logic                  beat_accept;
    logic                  final_beat;
    logic                  mismatch;
    logic                  addr_ok;
    logic [ADDR_WIDTH:0]   len_d;
    logic [ADDR_WIDTH:0]   beat_count_d;

    // Decode of the control conditions and the stage-2 compare. A length of
    // zero is widened to 2^ADDR_WIDTH so the run can cover the whole RAM.
    always_comb begin
        start_accept = start && ((state_q == IDLE) || (state_q == DONE));
        beat_accept  = in_valid && (state_q == RUN);
        beat_count_d = beat_count_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
        final_beat   = beat_accept && (beat_count_d == len_q);
        mismatch     = |(s1_sum_q ^ s1_exp_q);
        addr_ok      = (s1_addr_q == exp_idx_q);
        len_d        = (length == '0) ? {1'b1, {ADDR_WIDTH{1'b0}}}
                                      : {1'b0, length};
    end

    // Main FSM with the two-stage checking pipeline. An accepted start wipes
    // the run statistics; otherwise stage 2 folds the previous beat into the
    // counters. Stage 1 only ever loads while in RUN, so beats arriving in
    // any other state (including alongside a start in DONE) are dropped.
    always_ff @(posedge pll_clock) begin
        if (reset) begin
            state_q      <= IDLE;
            drain_cnt_q  <= 1'b0;
            pass_q       <= 1'b0;
            len_q        <= '0;
            beat_count_q <= '0;
            err_count_q  <= '0;
            seq_err_q    <= 1'b0;
            exp_idx_q    <= '0;
            s1_valid_q   <= 1'b0;
            s1_addr_q    <= '0;
            s1_sum_q     <= '0;
            s1_exp_q     <= '0;
        end else begin
            s1_valid_q <= beat_accept;
            if (beat_accept) begin
                s1_addr_q    <= in_addr;
                s1_sum_q     <= sum_in;
                s1_exp_q     <= exp_in;
                beat_count_q <= beat_count_d;
            end

            if (start_accept) begin
                len_q        <= len_d;
                beat_count_q <= '0;
                err_count_q  <= '0;
                seq_err_q    <= 1'b0;
                exp_idx_q    <= '0;
                pass_q       <= 1'b0;
            end else if (s1_valid_q) begin
                exp_idx_q <= exp_idx_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                if (mismatch && (err_count_q != ERR_MAX)) begin
                    err_count_q <= err_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end
                if (!addr_ok) begin
                    seq_err_q <= 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (start_accept) state_q <= RUN;
                end
                RUN: begin
                    if (final_beat) begin
                        state_q     <= DRAIN;
                        drain_cnt_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    // The last beat has cleared stage 2 by the second DRAIN
                    // cycle, so the counters are final when pass is latched.
                    if (drain_cnt_q) begin
                        state_q <= DONE;
                        pass_q  <= (err_count_q == '0) && !seq_err_q;
                    end else begin
                        drain_cnt_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (start_accept) state_q <= RUN;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = (state_q == RUN) || (state_q == DRAIN);
    assign done       = (state_q == DONE);
    assign pass       = pass_q;
    assign err_count  = err_count_q;
    assign beat_count = beat_count_q;
    assign seq_err    = seq_err_q;

`ifdef FIRST_ERR_CAPTURE_EN
    logic [ADDR_WIDTH-1:0] first_addr_q;
    logic [WIDTH-1:0]      first_sum_q;
    logic [WIDTH-1:0]      first_exp_q;

    // A zero error count means no mismatch has been seen yet in this run, so
    // it doubles as the "not yet captured" flag.
    always_ff @(posedge pll_clock) begin
        if (reset || start_accept) begin
            first_addr_q <= '0;
            first_sum_q  <= '0;
            first_exp_q  <= '0;
        end else if (s1_valid_q && mismatch && (err_count_q == '0)) begin
            first_addr_q <= s1_addr_q;
            first_sum_q  <= s1_sum_q;
            first_exp_q  <= s1_exp_q;
        end
    end

    assign first_err_addr = first_addr_q;
    assign first_err_sum  = first_sum_q;
    assign first_err_exp  = first_exp_q;
`else
    assign first_err_addr = '0;
    assign first_err_sum  = '0;
    assign first_err_exp  = '0;
`endif

endmodule

// File: doc/sum_result_checker.md
Name: sum_result_checker

Overview:
- Self-checking stage directly downstream of the clocked radix adder in the adder test harness.
- Consumes the adder's BITS_OUT-wide sum stream, one beat per pll_clock, in lockstep with a golden expected word and the result address from the write-address delay chain.
- Counts mismatches and flags address-sequence faults, so software reads a pass/fail summary instead of dumping the whole result RAM.
- Runs entirely in the pll_clock domain; status is sampled by the test control unit.

Parameters:
- WIDTH, 64, sum/expected word width in bits (BITS_OUT of the adder).
- ADDR_WIDTH, 9, result address width; maximum run length is 2^ADDR_WIDTH beats.
- CNT_WIDTH, 16, error counter width.

Ports:
- pll_clock  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse that arms a run.
- length  input  ADDR_WIDTH  beats in the run, sampled on accepted start; 0 means 2^ADDR_WIDTH.
- in_valid  input  1  sum_in/exp_in/in_addr valid this cycle.
- in_addr  input  ADDR_WIDTH  result address of this beat.
- sum_in  input  WIDTH  adder output word.
- exp_in  input  WIDTH  golden expected word.
- busy  output  1  high in RUN and while the pipeline drains.
- done  output  1  high in DONE.
- pass  output  1  done AND err_count==0 AND !seq_err.
- err_count  output  CNT_WIDTH  mismatching beats, saturating.
- beat_count  output  ADDR_WIDTH+1  beats accepted this run.
- seq_err  output  1  sticky; in_addr departed from 0,1,2,... order.
- first_err_addr  output  ADDR_WIDTH  address of first mismatch.
- first_err_sum  output  WIDTH  sum_in of first mismatch.
- first_err_exp  output  WIDTH  exp_in of first mismatch.

Behaviour:
- Reset: state=IDLE. All outputs 0, all internal registers 0. Reset mid-run aborts the run; no partial results are kept.
- FSM IDLE/RUN/DRAIN/DONE:
  - IDLE: start → RUN.
  - RUN: final beat accepted → DRAIN.
  - DRAIN: after 2 cycles → DONE.
  - DONE: start → RUN.
- Accepted start (in IDLE or DONE) clears err_count, beat_count, seq_err and first_err_*, and latches length.
- start in RUN or DRAIN is ignored.
- in_valid is ignored outside RUN.
- Pipeline:
  - S1 registers valid/addr/sum/exp.
  - S2 computes mismatch = |(sum^exp) and addr_ok = (addr == expected index), then updates counters.
  - err_count and seq_err reflect a beat 2 cycles after its in_valid.
- beat_count increments at S1 acceptance, so it reflects a beat 1 cycle after its in_valid. The final beat is the one where beat_count reaches the latched length.
- Beats are gapped freely; in_valid low stalls nothing.
- err_count saturates at 2^CNT_WIDTH-1; no wrap.
- seq_err sets on the first out-of-order address and stays set until the next accepted start. The beat is still compared and counted.
- A simultaneous start and in_valid in DONE: start is taken and the beat is ignored.
- done and pass hold until the next accepted start or reset.
- busy = (state==RUN)|(state==DRAIN).

Optional Feature:
- Macro FIRST_ERR_CAPTURE_EN.
- Defined: on the first mismatch after an accepted start, first_err_addr/sum/exp capture the S2 addr/sum/exp and then freeze.
- Undefined: the capture registers are not built and first_err_* are tied to 0.
- Counting and pass are identical in both builds.

Test Plan:
- Reset, then start with length=4 and 4 matching beats at addr 0..3 → done high 2 cycles after the last beat; pass=1, err_count=0, beat_count=4.
- length=8, beats 3 and 5 with sum_in=exp_in^1 → err_count=2, pass=0. With FIRST_ERR_CAPTURE_EN: first_err_addr=3, first_err_sum=exp^1, first_err_exp=exp.
- length=4, addresses 0,1,3,2 all matching → seq_err=1, err_count=0, pass=0. A restart via start clears seq_err.
- CNT_WIDTH=2, length=6, every beat mismatching → err_count=3 (saturated), done=1.
- Reset asserted after 2 of 4 beats → all outputs 0 the next cycle. Subsequent in_valid is ignored until start.
- length=0 with 512 matching beats → done only after beat 512, beat_count=512. start pulsed during RUN has no effect.
